// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_gnt,
        input  i_imem_rvalid,
        input  i_imem_rdata
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_gnt,
        output i_imem_rvalid,
        output i_imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests, keeps at most two fetches in
// flight or buffered, and feeds decode through a registered output.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [31:0]        i_redirect_pc,
    fetch_unit_if.master       imem,
    output logic [31:0]        or_inst,
    output logic [31:0]        or_pc,
    output logic               or_valid,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, FLUSH = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [1:0]  outstanding, drop_cnt, fifo_cnt;
    logic [31:0] fifo_inst [2];
    logic [31:0] fifo_pc   [2];
    logic [31:0] tag_q     [2];
    logic        fifo_rd, fifo_wr, tag_rd, tag_wr;

    logic        req, grant, rv_acc, rv_drop, fifo_empty, bypass, push, pop;
    logic [1:0]  out_after, drop_after, drop_redir;
    logic [2:0]  drop_sum;

    // Handshake: o_imem_req is a valid that, once raised, holds with a stable
    // o_imem_addr until i_imem_gnt (ready) is seen; a request transfers on the
    // edge where both are high. i_imem_rvalid carries no backpressure.
    assign req        = (state == FETCH) && !i_redirect &&
                        (({1'b0, outstanding} + {1'b0, fifo_cnt}) < 3'd2);
    assign grant      = req && imem.i_imem_gnt;
    assign rv_acc     = imem.i_imem_rvalid && (drop_cnt == 2'd0);
    assign rv_drop    = imem.i_imem_rvalid && (drop_cnt != 2'd0);
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign bypass     = !i_stall && fifo_empty && rv_acc;
    assign push       = rv_acc && !bypass;
    assign pop        = !i_stall && !fifo_empty;

    // Stale responses still owed by memory once this cycle's traffic settles.
    assign out_after  = outstanding + {1'b0, grant} - {1'b0, rv_acc};
    assign drop_after = drop_cnt - {1'b0, rv_drop};
    assign drop_sum   = {1'b0, drop_after} + {1'b0, out_after};
    assign drop_redir = (drop_sum > 3'd2) ? 2'd2 : drop_sum[1:0];

    assign imem.o_imem_req  = req;
    assign imem.o_imem_addr = fetch_pc;
    assign dbg_state        = state;

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: if (i_redirect && (drop_redir != 2'd0)) state_nxt = FLUSH;
            FLUSH: begin
                if ((i_redirect ? drop_redir : drop_after) == 2'd0) state_nxt = FETCH;
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= BOOT;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            fifo_cnt    <= 2'd0;
            fifo_rd     <= 1'b0;
            fifo_wr     <= 1'b0;
            tag_rd      <= 1'b0;
            tag_wr      <= 1'b0;
            or_inst     <= NOP_INST;
            or_pc       <= 32'd0;
            or_valid    <= 1'b0;
        end else if (i_redirect) begin
            fetch_pc    <= i_redirect_pc & 32'hFFFF_FFFC;
            outstanding <= 2'd0;
            drop_cnt    <= drop_redir;
            fifo_cnt    <= 2'd0;
            fifo_rd     <= 1'b0;
            fifo_wr     <= 1'b0;
            tag_rd      <= 1'b0;
            tag_wr      <= 1'b0;
            or_inst     <= NOP_INST;
            or_pc       <= 32'd0;
            or_valid    <= 1'b0;
        end else begin
            if (grant) begin
                fetch_pc      <= fetch_pc + 32'd4;
                tag_q[tag_wr] <= fetch_pc;
                tag_wr        <= ~tag_wr;
            end
            if (rv_acc) tag_rd <= ~tag_rd;
            outstanding <= out_after;
            drop_cnt    <= drop_after;
            if (push) begin
                fifo_inst[fifo_wr] <= imem.i_imem_rdata;
                fifo_pc[fifo_wr]   <= tag_q[tag_rd];
                fifo_wr            <= ~fifo_wr;
            end
            if (pop) fifo_rd <= ~fifo_rd;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            // A response landing on an empty FIFO goes straight to decode.
            if (!i_stall) begin
                if (!fifo_empty) begin
                    or_inst  <= fifo_inst[fifo_rd];
                    or_pc    <= fifo_pc[fifo_rd];
                    or_valid <= 1'b1;
                end else if (rv_acc) begin
                    or_inst  <= imem.i_imem_rdata;
                    or_pc    <= tag_q[tag_rd];
                    or_valid <= 1'b1;
                end else begin
                    or_inst  <= NOP_INST;
                    or_pc    <= 32'd0;
                    or_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), which is the instruction word presented while or_valid=0.
REQ-003 SHALL have port i_clk, input, 1 bit: CPU clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_stall, input, 1 bit: decode hold request; freezes the output register.
REQ-006 SHALL have port i_redirect, input, 1 bit: branch/jump/trap taken; restarts fetch at i_redirect_pc.
REQ-007 SHALL have port i_redirect_pc, input, 32 bits: redirect target.
REQ-008 SHALL have port o_imem_req, output, 1 bit: instruction memory request valid.
REQ-009 SHALL have port o_imem_addr, output, 32 bits: request address, always word-aligned.
REQ-010 SHALL have port i_imem_gnt, input, 1 bit: request accepted this cycle.
REQ-011 SHALL have port i_imem_rvalid, input, 1 bit: read data valid; responses arrive in request order, at least 1 cycle after grant.
REQ-012 SHALL have port i_imem_rdata, input, 32 bits: instruction word.
REQ-013 SHALL have port or_inst, output reg, 32 bits: instruction to decode (decode i_inst).
REQ-014 SHALL have port or_pc, output reg, 32 bits: PC of or_inst (decode i_pc).
REQ-015 SHALL have port or_valid, output reg, 1 bit: or_inst/or_pc hold a real instruction.

Function
REQ-016 SHALL hold state fetch_pc (32b), an outstanding counter (0..2), a drop counter (0..2), and a 2-entry in-order FIFO of {inst, pc}; the FIFO pc comes from a 2-entry tag queue written at grant.
REQ-017 SHALL implement FSM states BOOT, FETCH, FLUSH:
  - BOOT -> FETCH unconditionally, one cycle after reset release.
  - FETCH -> FLUSH on i_redirect when outstanding minus same-cycle rvalid is nonzero.
  - FLUSH -> FETCH when the drop counter reaches 0.
REQ-018 SHALL assert o_imem_req only in FETCH, without i_redirect, and when outstanding + fifo_count < 2 (values at cycle start); o_imem_addr = fetch_pc.
REQ-019 SHALL, once o_imem_req is asserted, hold o_imem_req and o_imem_addr stable until i_imem_gnt, unless i_redirect or reset occurs.
REQ-020 SHALL, on a cycle with o_imem_req and i_imem_gnt both high, set fetch_pc += 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0), increment outstanding, and push the address into the tag queue.
REQ-021 SHALL, on i_imem_rvalid with drop counter = 0, decrement outstanding and push {rdata, tag} into the FIFO.
REQ-022 SHALL, on i_imem_rvalid with drop counter > 0, decrement both counters and discard the data.
REQ-023 SHALL, without i_stall, load the output register from the FIFO head (or_valid=1) and pop it; with the FIFO empty it SHALL load or_inst=NOP_INST, or_pc=0, or_valid=0.
REQ-024 SHALL hold or_inst, or_pc and or_valid unchanged while i_stall=1; FIFO and requests continue, subject to REQ-018.
REQ-025 SHALL give a fetch-to-decode latency of grant cycle + memory latency + 1 cycle; a response arriving to an empty FIFO with no stall SHALL appear on outputs the next edge (FIFO bypass).
REQ-026 SHALL sustain one instruction per cycle with 1-cycle memory and no stall.
REQ-027 SHALL apply these actions on i_redirect (priority over i_stall):
  - fetch_pc <= {i_redirect_pc[31:2],2'b00};
  - FIFO and tag queue cleared;
  - drop counter <= outstanding after this cycle's grant/rvalid;
  - outstanding <= 0;
  - output register <= NOP_INST, pc 0, or_valid 0;
  - no request that cycle.
REQ-028 SHALL handle a redirect in FLUSH: new target, drop counter accumulates (saturating at 2), stays in FLUSH.
REQ-029 SHALL handle a simultaneous grant and redirect: the granted request counts toward the drop counter.

Reset
REQ-030 SHALL, on i_rst_n=0 at a clock edge:
  - FSM = BOOT, fetch_pc = RESET_PC;
  - counters = 0, FIFO empty;
  - or_inst = NOP_INST, or_pc = 0, or_valid = 0.
REQ-031 SHALL keep o_imem_req = 0 during reset and in BOOT; a reset mid-transaction abandons outstanding responses, and the environment SHALL also reset the memory.

Verification
REQ-032 SHALL cover reset then 1-cycle memory, gnt always 1: requests at 0,4,8,...; or_valid=1 from cycle 3 with or_pc 0,4,8 on consecutive cycles.
REQ-033 SHALL cover i_stall held 3 cycles with the FIFO filling: outputs frozen, o_imem_req drops when fifo+outstanding=2, no instruction lost or duplicated after release.
REQ-034 SHALL cover redirect to 32'h0000_0103 with 2 outstanding: next request addr 32'h0000_0100, both stale responses discarded, first valid or_pc=32'h100.
REQ-035 SHALL cover gnt withheld 4 cycles: o_imem_req/o_imem_addr stable; then grant: fetch_pc advances by exactly 4.
REQ-036 SHALL cover RESET_PC=32'hFFFF_FFF8, no stall: or_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 SHALL cover redirect coincident with rvalid, grant and i_stall: output becomes NOP/invalid, drop count correct, later instructions come only from the new target.
